// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-port register file with a per-register scoreboard
// (busy) bit and a sequential whole-file clear engine.
//
// Port priority: write port 1 beats write port 0 on an address collision.
// An issue (busy set) beats a write-back (busy clear) on the same register.
// While the clear engine runs, every write, issue and clear request is
// dropped, and reads see stored contents only, with no write bypass.
// clr_busy is the registered image of the clear FSM state, so it is high
// exactly while the FSM sits in CLEAR.
module reg_file_sb #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr0_en,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    input  logic              wr1_en,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    input  logic [ADDR_W-1:0] rd0_addr,
    output logic [DATA_W-1:0] rd0_data,
    output logic              rd0_busy,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic [DATA_W-1:0] rd1_data,
    output logic              rd1_busy,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic              clr_req,
    output logic              clr_busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              clr_busy_q;
    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;

    logic idle;
    logic wr0_ok;
    logic wr1_ok;
    logic iss_ok;

    // Address 0 is a hardwired zero register only when ZERO_REG is set.
    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Qualified requests: only honoured in IDLE and never to the zero register.
    assign idle   = (state_q == ST_IDLE);
    assign wr0_ok = idle && wr0_en && !is_zero_reg(wr0_addr);
    assign wr1_ok = idle && wr1_en && !is_zero_reg(wr1_addr);
    assign iss_ok = idle && iss_en && !is_zero_reg(iss_addr);

    // Read port 0: zero register, then same-cycle write bypass (wr1 first), then storage.
    always_comb begin
        rd0_data = regs_q[rd0_addr];
        if (is_zero_reg(rd0_addr)) begin
            rd0_data = '0;
        end else if (wr1_ok && (wr1_addr == rd0_addr)) begin
            rd0_data = wr1_data;
        end else if (wr0_ok && (wr0_addr == rd0_addr)) begin
            rd0_data = wr0_data;
        end
    end

    // Read port 1: same selection as port 0.
    always_comb begin
        rd1_data = regs_q[rd1_addr];
        if (is_zero_reg(rd1_addr)) begin
            rd1_data = '0;
        end else if (wr1_ok && (wr1_addr == rd1_addr)) begin
            rd1_data = wr1_data;
        end else if (wr0_ok && (wr0_addr == rd1_addr)) begin
            rd1_data = wr0_data;
        end
    end

    // Busy flags come straight from storage; no bypass of issue or write-back.
    assign rd0_busy = busy_q[rd0_addr] && !is_zero_reg(rd0_addr);
    assign rd1_busy = busy_q[rd1_addr] && !is_zero_reg(rd1_addr);
    assign clr_busy = clr_busy_q;

    // Scoreboard next state: clear engine zeroes its entry, else write-backs clear and issue sets last.
    always_comb begin
        busy_d = busy_q;
        if (state_q == ST_CLEAR) begin
            busy_d[cnt_q] = 1'b0;
        end else begin
            if (wr0_ok) busy_d[wr0_addr] = 1'b0;
            if (wr1_ok) busy_d[wr1_addr] = 1'b0;
            if (iss_ok) busy_d[iss_addr] = 1'b1;
        end
    end

    // Scoreboard storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Register storage: clear engine zeroes one entry per cycle, otherwise wr1 wins over wr0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (state_q == ST_CLEAR) begin
                    if (cnt_q == ADDR_W'(i)) begin
                        regs_q[i] <= '0;
                    end
                end else if (wr1_ok && (wr1_addr == ADDR_W'(i))) begin
                    regs_q[i] <= wr1_data;
                end else if (wr0_ok && (wr0_addr == ADDR_W'(i))) begin
                    regs_q[i] <= wr0_data;
                end
            end
        end
    end

    // Clear FSM: IDLE -> CLEAR on request, walk the counter over every entry, return after the last one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            clr_busy_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (clr_req) begin
                        state_q    <= ST_CLEAR;
                        cnt_q      <= '0;
                        clr_busy_q <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (cnt_q == {ADDR_W{1'b1}}) begin
                        state_q    <= ST_IDLE;
                        cnt_q      <= '0;
                        clr_busy_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    cnt_q      <= '0;
                    clr_busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
